bias_add_scheduler: RTL and testbench

Sequences per-channel bias addition for one convolution layer. It takes a flat bank of constant biases (N_GROUPS groups of N_adder_tree lanes, built from the per-group 18-bit bias constant modules) and a stream of accumulator beats. It adds the bias of the current output-channel group lane-wise with signed saturation, and advances the group after PIXELS_PER_GROUP beats. It sits between the adder-tree accumulators and the activation/requantisation stage.

---
 rtl/bias_add_scheduler.sv | 144 ++++++++++++++
 tb/tb_bias_add_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_scheduler.sv
// Per-channel bias addition sequencer: adds the current group's biases lane-wise with signed
// saturation to each accumulator beat, advancing the group every PIXELS_PER_GROUP beats.
module bias_add_scheduler #(
    parameter int unsigned N_adder_tree     = 16,
    parameter int unsigned N_GROUPS         = 4,
    parameter int unsigned PIXELS_PER_GROUP = 49,
    localparam int unsigned GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    localparam int unsigned PW = (PIXELS_PER_GROUP > 1) ? $clog2(PIXELS_PER_GROUP) : 1,
    localparam int unsigned DW = N_adder_tree * 18
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [N_GROUPS*N_adder_tree*18-1:0] bias_bus,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DW-1:0]                   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DW-1:0]                   out_data,
    output logic [GW-1:0]                   out_group,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   group_q, group_d;
    logic [PW-1:0]   pixel_q, pixel_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [GW-1:0]   out_group_q, out_group_d;

    logic            out_free;
    logic            accept;
    logic            last_pixel;
    logic            last_group;
    logic [DW-1:0]   biased;
    logic [17:0]     lane_a, lane_b;
    logic [18:0]     lane_sum;

    // Output register may be refilled in the same cycle it is drained.
    assign out_free   = !out_valid_q || out_ready;
    assign in_ready   = (state_q == StRun) && out_free;
    assign accept     = in_valid && in_ready;
    assign last_pixel = (pixel_q == PW'(PIXELS_PER_GROUP - 1));
    assign last_group = (group_q == GW'(N_GROUPS - 1));

    always_comb begin
        biased   = '0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
        for (int l = 0; l < int'(N_adder_tree); l++) begin
            lane_a   = in_data[18*l +: 18];
            lane_b   = bias_bus[18*(int'(group_q)*int'(N_adder_tree) + l) +: 18];
            lane_sum = {lane_a[17], lane_a} + {lane_b[17], lane_b};
            // Top two bits disagree only on overflow; bit 18 gives the true sign.
            if (lane_sum[18] == lane_sum[17]) begin
                biased[18*l +: 18] = lane_sum[17:0];
            end else if (!lane_sum[18]) begin
                biased[18*l +: 18] = 18'h1FFFF;
            end else begin
                biased[18*l +: 18] = 18'h20000;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        group_d = group_q;
        pixel_d = pixel_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    group_d = '0;
                    pixel_d = '0;
                end
            end
            StRun: begin
                if (accept) begin
                    if (last_pixel) begin
                        pixel_d = '0;
                        if (last_group) begin
                            group_d = '0;
                            state_d = StDrain;
                        end else begin
                            group_d = group_q + 1'b1;
                        end
                    end else begin
                        pixel_d = pixel_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_free) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_group_d = out_group_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = biased;
            out_group_d = group_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            group_q     <= '0;
            pixel_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_group_q <= '0;
        end else begin
            state_q     <= state_d;
            group_q     <= group_d;
            pixel_q     <= pixel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_group_q <= out_group_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_group = out_group_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bias_add_scheduler.sv
// Self-checking bench for bias_add_scheduler: vector table plus scoreboard of expected beats.
module tb_bias_add_scheduler;

    localparam int unsigned NL  = 4;
    localparam int unsigned NG  = 4;
    localparam int unsigned PPG = 3;
    localparam int unsigned DW  = NL * 18;
    localparam int unsigned GW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [NG*NL*18-1:0] bias_bus;
    logic [DW-1:0]     in_data = '0;
    logic              in_ready, out_valid, busy, done;
    logic [DW-1:0]     out_data;
    logic [GW-1:0]     out_group;

    bias_add_scheduler #(
        .N_adder_tree    (NL),
        .N_GROUPS        (NG),
        .PIXELS_PER_GROUP(PPG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bias_bus (bias_bus),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_group(out_group),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [GW-1:0] grp;
        bit            has_vec;
        int            vec;
    } exp_t;

    typedef struct {
        int din;
        int dout;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[NG*PPG];
    int            n_checks = 0;
    int            n_pass = 0;
    int            beat_idx = 0;
    int            done_cnt = 0;
    int            n_out = 0;
    bit            hold_pend = 0;
    logic [DW-1:0] held_data;
    logic [GW-1:0] held_group;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic int sat(input int a, input int b);
        int s;
        s = a + b;
        if (s > 131071) return 131071;
        if (s < -131072) return -131072;
        return s;
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input int g);
        logic [DW-1:0]      r;
        logic signed [17:0] x, y;
        int                 s;
        r = '0;
        for (int l = 0; l < int'(NL); l++) begin
            x = d[18*l +: 18];
            y = bias_bus[18*(g*int'(NL) + l) +: 18];
            s = sat(int'(x), int'(y));
            r[18*l +: 18] = s[17:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int lane0);
        logic [DW-1:0] r;
        logic [31:0]   t;
        r = '0;
        for (int l = 1; l < int'(NL); l++) begin
            t = $urandom;
            r[18*l +: 18] = t[17:0];
        end
        r[17:0] = lane0[17:0];
        return r;
    endfunction

    task automatic set_bias(input int g, input int val);
        bias_bus[18*(g*int'(NL)) +: 18] = val[17:0];
    endtask

    // One cycle: drive at negedge, observe 1ns later, advance to the next negedge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic st,
                        input bit hv, input int ve, output bit acc);
        exp_t               e;
        logic signed [17:0] l0;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        start     = st;
        #1;
        if (hold_pend) begin
            check("hold_valid", out_valid, 1);
            check_data("hold_data", out_data, held_data);
            check("hold_group", out_group, held_group);
        end
        check("valid_vs_scoreboard", out_valid, sb.size() != 0);
        if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check_data("out_data", out_data, e.data);
            check("out_group", out_group, e.grp);
            if (e.has_vec) begin
                l0 = out_data[17:0];
                check("vec_lane0", l0, e.vec);
            end
            n_out++;
        end
        acc = v && in_ready;
        if (acc) begin
            e.data    = model(d, beat_idx / int'(PPG));
            e.grp     = GW'(beat_idx / int'(PPG));
            e.has_vec = hv;
            e.vec     = ve;
            sb.push_back(e);
            beat_idx++;
        end
        if (done) done_cnt++;
        hold_pend  = out_valid && !out_ready;
        held_data  = out_data;
        held_group = out_group;
        @(negedge clk);
    endtask

    task automatic run_pass(input bit rand_ready, input bit use_vecs, input int start_mid_at);
        bit            acc;
        int            guard;
        logic [DW-1:0] d;
        beat_idx = 0;
        done_cnt = 0;
        n_out    = 0;
        step(1'b0, '0, 1'b1, 1'b1, 0, 0, acc);
        check("busy_after_start", busy, 1);
        for (int k = 0; k < int'(NG*PPG); k++) begin
            d = mk_data(use_vecs ? vecs[k].din : int'($urandom_range(0, 262143)) - 131072);
            acc   = 0;
            guard = 0;
            while (!acc && guard < 20) begin
                step(1'b1, d, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, k == start_mid_at,
                     use_vecs, vecs[k].dout, acc);
                guard++;
            end
            if (!acc) check("accept_timeout", 0, 1);
        end
        guard = 0;
        // start held high through drain: covers start while busy and on the done cycle
        while (done_cnt == 0 && guard < 20) begin
            step(1'b0, '0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1, 0, 0, acc);
            guard++;
        end
        check("done_count", done_cnt, 1);
        check("output_count", n_out, NG*PPG);
        check("busy_after_done", busy, 0);
        check("done_after_done", done, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0, 0, acc);
        check("idle_stays_idle", busy, 0);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        bit acc;
        for (int i = 0; i < int'(NG*NL); i++) bias_bus[18*i +: 18] = 18'($urandom);
        set_bias(0, 2436);
        set_bias(1, -180);
        set_bias(2, 131071);
        set_bias(3, -131072);
        vecs[0]  = '{1000, 3436};
        vecs[1]  = '{131071, 131071};
        vecs[2]  = '{-2436, 0};
        vecs[3]  = '{-131072, -131072};
        vecs[4]  = '{100, -80};
        vecs[5]  = '{-130892, -131072};
        vecs[6]  = '{1, 131071};
        vecs[7]  = '{0, 131071};
        vecs[8]  = '{-131072, -1};
        vecs[9]  = '{-1, -131072};
        vecs[10] = '{131071, -1};
        vecs[11] = '{0, -131072};

        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check_data("rst_out_data", out_data, '0);
        check("rst_out_group", out_group, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_pass(0, 1, -1);
        run_pass(1, 0, 5);
        run_pass(1, 1, 7);

        // Reset in flight: out_valid held by a stall mid-group
        beat_idx = 0;
        step(1'b0, '0, 1'b1, 1'b1, 0, 0, acc);
        for (int k = 0; k < 4; k++) step(1'b1, mk_data(k), 1'b1, 1'b0, 0, 0, acc);
        step(1'b1, mk_data(9), 1'b0, 1'b0, 0, 0, acc);
        check("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check_data("mid_rst_out_data", out_data, '0);
        check("mid_rst_out_group", out_group, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        sb.delete();
        hold_pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(0, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
